// File: rtl/bcd_pkg.sv
// Shared types and constants for the arbitrated binary-to-BCD converter.
package bcd_pkg;

    localparam int W_BIN = 8;
    localparam int W_BCD = 12;
    localparam int CNT_W = 4;
    localparam int IDX_W = 2;

    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Double-dabble digit correction applied before each shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= ADD3_THRESH) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// Shift-and-add-3 datapath: one double-dabble step per asserted step strobe.
module bcd_dd_core
    import bcd_pkg::*;
#(
    parameter int W = 8
)
(
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     din,
    output logic [W_BCD-1:0] result
);

    localparam int SR_W = W_BCD + W;

    logic [SR_W-1:0] r_sr;
    logic [SR_W-1:0] w_adj;
    logic [SR_W-1:0] w_next;

    // Hundreds never reaches 5 for an 8-bit operand, so only ones and tens are corrected.
    always_comb begin
        w_adj          = r_sr;
        w_adj[W+3:W]   = dd_adjust(r_sr[W+3:W]);
        w_adj[W+7:W+4] = dd_adjust(r_sr[W+7:W+4]);
        w_next         = w_adj << 1;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            r_sr <= {{W_BCD{1'b0}}, din};
        end else if (step) begin
            r_sr <= w_next;
        end
    end

    // Result reflects the step in flight, so the final step's value is capturable at the same edge.
    assign result = w_next[SR_W-1 -: W_BCD];

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one serial binary-to-BCD converter among N_REQ requesters.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W_BIN = bcd_pkg::W_BIN
)
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*W_BIN-1:0] din,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       done_id,
    output logic [W_BCD-1:0]       bcd
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W_BIN - 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W:0]     w_sum;
    logic               w_any;
    logic               w_load;
    logic               w_step;
    logic               w_last_step;
    logic [W_BIN-1:0]   w_din_sel;
    logic [W_BCD-1:0]   w_res;

    // Scan farthest-first so the nearest requester after the pointer wins.
    always_comb begin
        w_sel  = r_last;
        w_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_sum = {1'b0, r_last} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (req[w_cand]) begin
                w_sel = w_cand;
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_din_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_din_sel = din[i*W_BIN +: W_BIN];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                w_step = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_last_step = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The pointer doubles as the in-flight requester index, since it moves only on a grant.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt   <= '0;
            r_last  <= PTR_RST;
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            bcd     <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            if (w_load) begin
                r_cnt  <= '0;
                r_last <= w_sel;
                gnt    <= N_REQ'(1) << w_sel;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last_step) begin
                done    <= 1'b1;
                done_id <= r_last;
                bcd     <= w_res;
            end
        end
    end

    assign busy = (r_state == CONV);

    bcd_dd_core #(
        .W (W_BIN)
    ) u_core (
        .clk    (clk),
        .load   (w_load),
        .step   (w_step),
        .din    (w_din_sel),
        .result (w_res)
    );

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed and randomized bench for bcd_conv_arbiter with a decimal/round-robin reference model.
module tb_bcd_conv_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         clr;
    logic [N-1:0] req;
    logic [N*8-1:0] din;
    logic [N-1:0] gnt;
    logic         busy;
    logic         done;
    logic [1:0]   done_id;
    logic [11:0]  bcd;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;
    int rr_last = N - 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_conv_arbiter #(
        .N_REQ (N),
        .W_BIN (8)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .bcd     (bcd)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dec_bcd(input int v);
        return 32'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        clr = 1'b1;
        req = '0;
        tick();
        tick();
        clr = 1'b0;
        rr_last = N - 1;
    endtask

    task automatic wait_gnt(output int idx, output int at);
        idx = -1;
        at  = 0;
        for (int k = 0; k < 40; k++) begin
            if (gnt != '0) begin
                for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
                at = cyc;
                return;
            end
            tick();
        end
        check("gnt_timeout", 0, 1);
    endtask

    // Follows one conversion from its grant to one cycle past its done pulse.
    task automatic xfer(input int exp_idx, input int exp_val, input bit drop,
                        input int new_din, output int at);
        int idx;
        bit saw;
        wait_gnt(idx, at);
        if (idx < 0) return;
        check("gnt_idx", idx, exp_idx);
        check("gnt_onehot", 32'(gnt), 32'(1) << exp_idx);
        check("busy_in_gnt", 32'(busy), 1);
        rr_last = idx;
        if (drop) req[idx] = 1'b0;
        if (new_din >= 0) din[idx*8 +: 8] = 8'(new_din);
        tick();
        check("gnt_one_cycle", 32'(gnt), 0);
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done) saw = 1'b1;
            tick();
        end
        check("done_early", 32'(saw), 0);
        check("busy_last_conv", 32'(busy), 1);
        tick();
        check("done_pulse", 32'(done), 1);
        check("bcd_value", 32'(bcd), dec_bcd(exp_val));
        check("bcd_hi_zero", 32'(bcd[11:10]), 0);
        check("done_id", 32'(done_id), exp_idx);
        check("busy_after_done", 32'(busy), 0);
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("bcd_held", 32'(bcd), dec_bcd(exp_val));
    endtask

    initial begin
        int at;
        int prev;
        int idx;
        int e;
        bit saw;
        logic [N-1:0] pend;
        int vals [N];
        int seq_f [4];

        clr = 1'b1;
        req = '0;
        din = '0;
        tick();
        tick();
        clr = 1'b0;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_done_id", 32'(done_id), 0);
        check("rst_bcd", 32'(bcd), 0);
        tick();
        tick();
        check("idle_gnt", 32'(gnt), 0);
        check("idle_busy", 32'(busy), 0);

        // Single request, maximum operand.
        din[7:0] = 8'd255;
        req = 4'b0001;
        xfer(0, 255, 1'b1, -1, at);

        // Simultaneous requests served in index order, 9 cycles apart.
        do_reset();
        din = {8'd0, 8'd128, 8'd99, 8'd0};
        req = 4'b0111;
        vals[0] = 0; vals[1] = 99; vals[2] = 128;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            xfer(i, vals[i], 1'b1, -1, at);
            if (i > 0) check("sim_spacing", at - prev, 9);
            prev = at;
        end

        // Fairness with two requesters held high.
        do_reset();
        din = {8'd201, 8'd0, 8'd0, 8'd42};
        req = 4'b1001;
        seq_f[0] = 0; seq_f[1] = 3; seq_f[2] = 0; seq_f[3] = 3;
        for (int i = 0; i < 4; i++) begin
            xfer(seq_f[i], (seq_f[i] == 0) ? 42 : 201, 1'b0, -1, at);
            if (i > 0) check("fair_spacing", at - prev, 9);
            prev = at;
        end

        // Operand captured at the grant edge only.
        do_reset();
        din = '0;
        din[7:0] = 8'd100;
        req = 4'b0001;
        xfer(0, 100, 1'b1, 37, at);

        // Abort in the 4th conversion cycle.
        din[7:0] = 8'd200;
        req = 4'b0001;
        wait_gnt(idx, at);
        check("abort_gnt_idx", idx, 0);
        req = '0;
        tick();
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rr_last = N - 1;
        check("abort_gnt", 32'(gnt), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_done_id", 32'(done_id), 0);
        check("abort_bcd", 32'(bcd), 0);
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) saw = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(saw), 0);
        din[7:0] = 8'd9;
        req = 4'b0001;
        xfer(0, 9, 1'b1, -1, at);

        // Randomized request masks and operands against the reference model.
        do_reset();
        pend = '0;
        for (int r = 0; r < 30; r++) begin
            if (pend == '0) begin
                pend = N'($urandom_range(1, (1 << N) - 1));
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) begin
                        vals[i] = int'($urandom_range(0, 255));
                        din[i*8 +: 8] = 8'(vals[i]);
                    end
                end
                req = pend;
            end
            e = rr_pick(pend, rr_last);
            xfer(e, vals[e], 1'b1, int'($urandom_range(0, 255)), at);
            pend[e] = 1'b0;
        end

        // Full operand sweep on requester 2.
        do_reset();
        din = '0;
        for (int v = 0; v < 256; v++) begin
            din[23:16] = 8'(v);
            req = 4'b0100;
            xfer(2, v, 1'b1, -1, at);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
